// File: rtl/nmi_bus_arbiter.sv
// Round-robin two-master NMI arbiter with one outstanding access.
// A watchdog completes unanswered accesses and records the address.
module nmi_bus_arbiter #(
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        err_o,
  output logic [31:0] err_addr_o,
  input  logic        err_clr_i
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t        state;
  logic          grant;
  logic          last_grant;
  logic [CW-1:0] count;

  logic in_busy;
  logic in_err;
  logic g_valid;
  logic s_done;
  logic done;

  assign in_busy = (state == BUSY);
  assign in_err  = (state == ERR);
  assign g_valid = grant ? m1_valid : m0_valid;

  // Slave side follows the granted master only while BUSY.
  assign s_valid = in_busy & g_valid;
  assign s_addr  = in_busy ? (grant ? m1_addr  : m0_addr)  : '0;
  assign s_wdata = in_busy ? (grant ? m1_wdata : m0_wdata) : '0;
  assign s_wstrb = in_busy ? (grant ? m1_wstrb : m0_wstrb) : '0;

  // Completion is either the slave answering or the watchdog cycle.
  assign s_done   = s_valid & s_ready;
  assign done     = s_done | in_err;
  assign m0_ready = ~grant & done;
  assign m1_ready = grant & done;
  assign m0_rdata = m0_ready ? (in_err ? ERR_RDATA : s_rdata) : '0;
  assign m1_rdata = m1_ready ? (in_err ? ERR_RDATA : s_rdata) : '0;

  // Arbitration FSM, watchdog counter and sticky error capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      count      <= '0;
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else begin
      if (err_clr_i) err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m0_valid | m1_valid) begin
            grant <= (m0_valid & m1_valid) ? ~last_grant : m1_valid;
            count <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!g_valid) begin
            state <= IDLE;
          end else if (s_ready) begin
            last_grant <= grant;
            state      <= IDLE;
          end else if (count == CNT_LAST) begin
            err_addr_o <= s_addr;
            state      <= ERR;
          end else begin
            count <= count + CW'(1);
          end
        end
        ERR: begin
          err_o      <= 1'b1;
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nmi_bus_arbiter.sv
// Self-checking bench for nmi_bus_arbiter: directed cases with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_nmi_bus_arbiter;

  localparam int          T    = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;
  logic        m0_valid = 0, m1_valid = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 0;
  logic [31:0] s_rdata = 0;
  logic        err_o;
  logic [31:0] err_addr_o;
  logic        err_clr_i = 0;

  nmi_bus_arbiter #(.TIMEOUT_CYC(T), .ERR_RDATA(ERRD)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .err_o(err_o), .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level model: who owns the bus, how long it has waited.
  bit          mdl_ok = 0;
  int          owner = -1;
  int          waited = 0;
  bit          timed_out = 0;
  int          m_last = 1;
  bit          m_err = 0;
  logic [31:0] m_eaddr = 0;
  bit          exp_r[2];

  // Snapshots of DUT outputs taken at the negedge of the last tick.
  logic        ob_m0_ready, ob_m1_ready, ob_s_valid, ob_err;
  logic [31:0] ob_m0_rdata, ob_m1_rdata, ob_s_addr, ob_s_wdata, ob_eaddr;
  logic [3:0]  ob_s_wstrb;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare at negedge, advance model, return after posedge.
  task automatic tick();
    logic        v[2];
    logic [31:0] a[2];
    logic [31:0] d[2];
    logic [3:0]  s[2];
    logic        r[2];
    logic [31:0] rd[2];
    bit          e_sv;
    bit          set_err;
    v[0] = m0_valid; v[1] = m1_valid;
    a[0] = m0_addr;  a[1] = m1_addr;
    d[0] = m0_wdata; d[1] = m1_wdata;
    s[0] = m0_wstrb; s[1] = m1_wstrb;
    @(negedge clk);
    ob_m0_ready = m0_ready; ob_m1_ready = m1_ready;
    ob_m0_rdata = m0_rdata; ob_m1_rdata = m1_rdata;
    ob_s_valid  = s_valid;  ob_s_addr   = s_addr;
    ob_s_wdata  = s_wdata;  ob_s_wstrb  = s_wstrb;
    ob_err      = err_o;    ob_eaddr    = err_addr_o;
    exp_r[0] = 0; exp_r[1] = 0;
    r[0] = m0_ready; r[1] = m1_ready;
    rd[0] = m0_rdata; rd[1] = m1_rdata;
    if (mdl_ok) begin
      e_sv = 0;
      if (owner >= 0 && timed_out) begin
        exp_r[owner] = 1;
      end else if (owner >= 0) begin
        e_sv = v[owner];
        exp_r[owner] = v[owner] && s_ready;
      end
      check("s_valid", s_valid, e_sv);
      if (e_sv) begin
        check("s_addr", s_addr, a[owner]);
        check("s_wdata", s_wdata, d[owner]);
        check("s_wstrb", s_wstrb, s[owner]);
      end
      for (int i = 0; i < 2; i++) begin
        check($sformatf("m%0d_ready", i), r[i], exp_r[i]);
        if (exp_r[i])
          check($sformatf("m%0d_rdata", i), rd[i],
                timed_out ? ERRD : s_rdata);
      end
      check("err_o", err_o, m_err);
      check("err_addr_o", err_addr_o, m_eaddr);
    end
    set_err = 0;
    if (rst_i) begin
      mdl_ok = 1; owner = -1; waited = 0; timed_out = 0;
      m_last = 1; m_err = 0; m_eaddr = 0;
    end else if (mdl_ok) begin
      if (timed_out) begin
        set_err = 1; m_last = owner; owner = -1; timed_out = 0;
      end else if (owner < 0) begin
        if (v[0] || v[1]) begin
          owner  = (v[0] && v[1]) ? 1 - m_last : (v[0] ? 0 : 1);
          waited = 0;
        end
      end else if (!v[owner]) begin
        owner = -1;
      end else if (s_ready) begin
        m_last = owner; owner = -1;
      end else if (waited + 1 == T) begin
        timed_out = 1; m_eaddr = a[owner];
      end else begin
        waited++;
      end
      if (set_err) m_err = 1;
      else if (err_clr_i) m_err = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 0; m1_valid = 0; s_ready = 0; err_clr_i = 0;
    m0_wstrb = 0; m1_wstrb = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1; tick(); tick();
    rst_i = 0;
  endtask

  int svc;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    do_reset();
    tick();
    check("rst_s_valid", ob_s_valid, 0);
    check("rst_s_addr", ob_s_addr, 0);
    check("rst_m0_ready", ob_m0_ready, 0);
    check("rst_m1_rdata", ob_m1_rdata, 0);
    check("rst_err", ob_err, 0);
    check("rst_eaddr", ob_eaddr, 0);

    // m0 read, slave answers on the second BUSY cycle
    m0_valid = 1; m0_addr = 32'h1000_0000; m0_wstrb = 0;
    tick();
    tick();
    check("t1_sv_c1", ob_s_valid, 1);
    check("t1_rdy_c1", ob_m0_ready, 0);
    s_ready = 1; s_rdata = 32'h1234_5678;
    tick();
    check("t1_sv_c2", ob_s_valid, 1);
    check("t1_rdy_c2", ob_m0_ready, 1);
    check("t1_rdata", ob_m0_rdata, 32'h1234_5678);
    check("t1_m1_rdy", ob_m1_ready, 0);
    m0_valid = 0; s_ready = 0;
    tick();
    check("t1_sv_c3", ob_s_valid, 0);

    // both masters continuously valid from reset, slave always ready
    do_reset();
    m0_valid = 1; m0_addr = 32'h2000_0000;
    m1_valid = 1; m1_addr = 32'h3000_0000;
    s_ready = 1; s_rdata = 32'h0BAD_F00D;
    for (int c = 0; c < 9; c++) begin
      tick();
      check("t2_m0_rdy", ob_m0_ready, (c == 1 || c == 5));
      check("t2_m1_rdy", ob_m1_ready, (c == 3 || c == 7));
    end
    idle_inputs();
    tick();

    // m1 write, slave ready on the third BUSY cycle
    m1_valid = 1; m1_addr = 32'h1000_0400;
    m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'hF;
    tick();
    for (int b = 1; b <= 3; b++) begin
      s_ready = (b == 3);
      tick();
      check("t3_s_addr", ob_s_addr, 32'h1000_0400);
      check("t3_s_wdata", ob_s_wdata, 32'hA5A5_A5A5);
      check("t3_s_wstrb", ob_s_wstrb, 4'hF);
      check("t3_m1_rdy", ob_m1_ready, (b == 3));
    end
    idle_inputs();
    tick();
    check("t3_m1_rdy_after", ob_m1_ready, 0);

    // unmapped m0 read, watchdog completes it
    m0_valid = 1; m0_addr = 32'h7000_0000; m0_wstrb = 0;
    tick();
    svc = 0;
    for (int b = 1; b <= T; b++) begin
      tick();
      if (ob_s_valid) svc++;
      check("t4_no_rdy", ob_m0_ready, 0);
    end
    check("t4_sv_cycles", svc, T);
    tick();
    check("t4_err_rdy", ob_m0_ready, 1);
    check("t4_err_rdata", ob_m0_rdata, 32'hDEAD_BEEF);
    check("t4_err_sv", ob_s_valid, 0);
    m0_valid = 0;
    tick();
    check("t4_err_o", ob_err, 1);
    check("t4_err_addr", ob_eaddr, 32'h7000_0000);
    err_clr_i = 1;
    tick();
    err_clr_i = 0;
    tick();
    check("t4_err_clr", ob_err, 0);
    check("t4_addr_kept", ob_eaddr, 32'h7000_0000);

    // slave answers on the last BUSY cycle: no error
    m0_valid = 1; m0_addr = 32'h1000_0010;
    tick();
    for (int b = 1; b <= T; b++) begin
      s_ready = (b == T); s_rdata = 32'hCAFE_0001;
      tick();
    end
    check("t5_rdy", ob_m0_ready, 1);
    check("t5_rdata", ob_m0_rdata, 32'hCAFE_0001);
    idle_inputs();
    tick();
    check("t5_no_err", ob_err, 0);
    check("t5_no_err_rdy", ob_m0_ready, 0);

    // reset in the second BUSY cycle of an m1 access
    m1_valid = 1; m1_addr = 32'h1000_0800; m1_wstrb = 0;
    tick();
    tick();
    rst_i = 1;
    tick();
    check("t6_busy2_sv", ob_s_valid, 1);
    check("t6_busy2_rdy", ob_m1_ready, 0);
    rst_i = 0;
    m0_valid = 1; m0_addr = 32'h1000_0900;
    tick();
    check("t6_after_sv", ob_s_valid, 0);
    check("t6_after_rdy", ob_m1_ready, 0);
    s_ready = 1;
    tick();
    check("t6_tie_sv", ob_s_valid, 1);
    check("t6_tie_addr", ob_s_addr, 32'h1000_0900);
    check("t6_tie_rdy", ob_m0_ready, 1);
    idle_inputs();
    tick();

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      s_ready   = (n < 2000) ? ($urandom % 2 == 0) : ($urandom % 12 == 0);
      s_rdata   = $urandom;
      err_clr_i = ($urandom % 16 == 0);
      rst_i     = ($urandom % 400 == 0);
      tick();
      if (m0_valid && exp_r[0]) m0_valid = 0;
      else if (m0_valid && $urandom % 64 == 0) m0_valid = 0;
      else if (!m0_valid && $urandom % 3 == 0) begin
        m0_valid = 1; m0_addr = $urandom;
        m0_wdata = $urandom; m0_wstrb = 4'($urandom);
      end
      if (m1_valid && exp_r[1]) m1_valid = 0;
      else if (m1_valid && $urandom % 64 == 0) m1_valid = 0;
      else if (!m1_valid && $urandom % 3 == 0) begin
        m1_valid = 1; m1_addr = $urandom;
        m1_wdata = $urandom; m1_wstrb = 4'($urandom);
      end
    end
    rst_i = 0;
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
